// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  localparam int unsigned MASK_W = 32;

  typedef enum logic [0:0] {
    UNCFG = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Right-justified mask of len ones; the caller truncates to its pattern width.
  function automatic logic [MASK_W-1:0] len_mask(input logic [5:0] len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(MASK_W); i++) begin
      if (i < int'(len)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the match count.
module seq_det_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with valid qualifier,
// overlap control and a saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 8,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               data_in,
  input  logic               data_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               data_out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_d;
  logic               err_d;
  logic               cnt_inc;
  logic               cnt_clr;

  logic               cfg_ok_c;
  logic [MAX_LEN-1:0] hist_nx_c;
  logic [LEN_W-1:0]   fill_nx_c;
  logic [MAX_LEN-1:0] mask_c;
  logic               hit_c;

  assign cfg_ok_c  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign hist_nx_c = {hist_q[MAX_LEN-2:0], data_in};
  assign fill_nx_c = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
  assign mask_c    = MAX_LEN'(len_mask(6'(len_q)));
  // Compare against the history as it will look after this beat shifts in.
  assign hit_c     = (fill_nx_c >= len_q) && (((hist_nx_c ^ pat_q) & mask_c) == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= UNCFG;
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      hist_q   <= '0;
      fill_q   <= '0;
      data_out <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      data_out <= match_d;
      cfg_err  <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    err_d   = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;

    case (state_q)
      UNCFG:   if (cfg_load && cfg_ok_c) state_d = ARMED;
      ARMED:   state_d = ARMED;
      default: state_d = UNCFG;
    endcase

    // A load in any state takes priority; a data beat in the same cycle is dropped.
    if (cfg_load) begin
      if (cfg_ok_c) begin
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        hist_d  = '0;
        fill_d  = '0;
        cnt_clr = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if ((state_q == ARMED) && data_valid) begin
      hist_d  = hist_nx_c;
      fill_d  = (hit_c && !ovl_q) ? '0 : fill_nx_c;
      match_d = hit_c;
      cnt_inc = hit_c;
    end
  end

  assign armed = (state_q == ARMED);

  seq_det_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: expected pulses are queued as
// each beat is driven and popped when the DUT output is sampled.
module tb_seq_detector_prog;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

  logic               clock;
  logic               reset;
  logic               data_in;
  logic               data_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;

  logic               data_out;
  logic [7:0]         match_count;
  logic               cfg_err;
  logic               armed;

  logic               data_out2;
  logic [1:0]         match_count2;
  logic               cfg_err2;
  logic               armed2;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_q[$];

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .data_out(data_out), .match_count(match_count),
    .cfg_err(cfg_err), .armed(armed)
  );

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .data_out(data_out2), .match_count(match_count2),
    .cfg_err(cfg_err2), .armed(armed2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic load_cfg(input logic [7:0] p, input logic [LEN_W-1:0] l, input logic o);
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    @(posedge clock); #1;
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    n_tests++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL reset_data_out: got %b want 0", data_out); end
    n_tests++; if (match_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", match_count); end
    n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed: got %b want 0", armed); end
    n_tests++; if (match_count2 !== 2'd0) begin n_fail++; $display("FAIL reset_count2: got %0d want 0", match_count2); end
    n_tests++; if (armed2 !== 1'b0) begin n_fail++; $display("FAIL reset_armed2: got %b want 0", armed2); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] exp  = 7'b0001001;
    logic e;
    load_cfg(8'b1011, 4'd4, 1'b1);
    n_tests++; if (armed !== 1'b1) begin n_fail++; $display("FAIL basic_armed: got %b want 1", armed); end
    n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL basic_cfg_err: got %b want 0", cfg_err); end
    for (int i = 0; i < 7; i++) begin
      data_in = bits[6-i]; data_valid = 1'b1; exp_q.push_back(exp[6-i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++; if (data_out !== e) begin n_fail++; $display("FAIL basic_bit%0d: data_out=%b want %b", i, data_out, e); end
    end
    data_valid = 1'b0;
    n_tests++; if (match_count !== 8'd2) begin n_fail++; $display("FAIL basic_count: got %0d want 2", match_count); end
  endtask

  task automatic test_overlap();
    logic [3:0] exp_ov = 4'b0111;
    logic [3:0] exp_no = 4'b0101;
    logic e;
    load_cfg(8'b11, 4'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      data_in = 1'b1; data_valid = 1'b1; exp_q.push_back(exp_ov[3-i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++; if (data_out !== e) begin n_fail++; $display("FAIL ovl1_bit%0d: data_out=%b want %b", i, data_out, e); end
    end
    data_valid = 1'b0;
    n_tests++; if (match_count !== 8'd3) begin n_fail++; $display("FAIL ovl1_count: got %0d want 3", match_count); end
    load_cfg(8'b11, 4'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      data_in = 1'b1; data_valid = 1'b1; exp_q.push_back(exp_no[3-i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++; if (data_out !== e) begin n_fail++; $display("FAIL ovl0_bit%0d: data_out=%b want %b", i, data_out, e); end
    end
    n_tests++; if (match_count !== 8'd2) begin n_fail++; $display("FAIL ovl0_count: got %0d want 2", match_count); end
    // One beat in, then a load with a concurrent beat: that beat must be dropped.
    data_in = 1'b1; @(posedge clock); #1;
    load_cfg(8'b11, 4'd2, 1'b0);
    n_tests++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL load_beat_out: got %b want 0", data_out); end
    n_tests++; if (match_count !== 8'd0) begin n_fail++; $display("FAIL load_clr_count: got %0d want 0", match_count); end
    for (int i = 0; i < 2; i++) begin
      data_in = 1'b1; data_valid = 1'b1; exp_q.push_back(i == 1);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++; if (data_out !== e) begin n_fail++; $display("FAIL load_discard_bit%0d: data_out=%b want %b", i, data_out, e); end
    end
    data_valid = 1'b0;
  endtask

  task automatic test_gaps();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] exp  = 7'b0001001;
    logic e;
    load_cfg(8'b1011, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      data_in = bits[6-i]; data_valid = 1'b1; exp_q.push_back(exp[6-i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++; if (data_out !== e) begin n_fail++; $display("FAIL gap_bit%0d: data_out=%b want %b", i, data_out, e); end
      for (int g = 0; g < 3; g++) begin
        data_in = 1'($urandom_range(1)); data_valid = 1'b0; exp_q.push_back(1'b0);
        @(posedge clock); #1;
        e = exp_q.pop_front();
        n_tests++; if (data_out !== e) begin n_fail++; $display("FAIL gap_idle%0d_%0d: data_out=%b want %b", i, g, data_out, e); end
      end
    end
    n_tests++; if (match_count !== 8'd2) begin n_fail++; $display("FAIL gap_count: got %0d want 2", match_count); end
  endtask

  task automatic test_cfg_err();
    logic [3:0] exp4 = 4'b0001;
    logic [3:0] bits4 = 4'b1011;
    logic [7:0] a5 = 8'hA5;
    logic e;
    load_cfg(8'hFF, 4'd0, 1'b0);
    n_tests++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_len0: cfg_err=%b want 1", cfg_err); end
    n_tests++; if (armed !== 1'b1) begin n_fail++; $display("FAIL err_len0_armed: got %b want 1", armed); end
    n_tests++; if (match_count !== 8'd2) begin n_fail++; $display("FAIL err_len0_count: got %0d want 2", match_count); end
    @(posedge clock); #1;
    n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width: cfg_err=%b want 0", cfg_err); end
    load_cfg(8'h00, 4'(MAX_LEN + 1), 1'b0);
    n_tests++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_len9: cfg_err=%b want 1", cfg_err); end
    n_tests++; if (armed !== 1'b1) begin n_fail++; $display("FAIL err_len9_armed: got %b want 1", armed); end
    // Stored 1011 config and history must have survived both rejected loads.
    for (int i = 0; i < 4; i++) begin
      data_in = bits4[3-i]; data_valid = 1'b1; exp_q.push_back(exp4[3-i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++; if (data_out !== e) begin n_fail++; $display("FAIL kept_cfg_bit%0d: data_out=%b want %b", i, data_out, e); end
    end
    data_valid = 1'b0;
    n_tests++; if (match_count !== 8'd3) begin n_fail++; $display("FAIL kept_cfg_count: got %0d want 3", match_count); end
    load_cfg(8'hA5, 4'(MAX_LEN), 1'b0);
    for (int i = 0; i < 8; i++) begin
      data_in = a5[7-i]; data_valid = 1'b1; exp_q.push_back(i == 7);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++; if (data_out !== e) begin n_fail++; $display("FAIL maxlen_bit%0d: data_out=%b want %b", i, data_out, e); end
    end
    data_valid = 1'b0;
    n_tests++; if (match_count !== 8'd1) begin n_fail++; $display("FAIL maxlen_count: got %0d want 1", match_count); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] bits4 = 4'b1011;
    logic [3:0] exp4  = 4'b0001;
    logic e;
    load_cfg(8'b1011, 4'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      data_in = bits4[3-i]; data_valid = 1'b1;
      @(posedge clock); #1;
    end
    reset = 1'b1; data_in = 1'b1;
    @(posedge clock); #1;
    n_tests++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL rmid_data_out: got %b want 0", data_out); end
    n_tests++; if (match_count !== 8'd0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", match_count); end
    n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL rmid_armed: got %b want 0", armed); end
    n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rmid_cfg_err: got %b want 0", cfg_err); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in = bits4[3-i]; data_valid = 1'b1; exp_q.push_back(1'b0);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++; if (data_out !== e) begin n_fail++; $display("FAIL unarmed_bit%0d: data_out=%b want %b", i, data_out, e); end
    end
    data_valid = 1'b0;
    n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL unarmed_armed: got %b want 0", armed); end
    load_cfg(8'b1011, 4'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      data_in = bits4[3-i]; data_valid = 1'b1; exp_q.push_back(exp4[3-i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++; if (data_out !== e) begin n_fail++; $display("FAIL rearm_bit%0d: data_out=%b want %b", i, data_out, e); end
    end
    data_valid = 1'b0;
  endtask

  task automatic test_saturate();
    logic e;
    int k;
    logic [1:0] exp_cnt;
    load_cfg(8'b11, 4'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      data_in = 1'b1; data_valid = 1'b1; exp_q.push_back(i % 2 == 1);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++; if (data_out2 !== e) begin n_fail++; $display("FAIL sat_pulse%0d: data_out=%b want %b", i, data_out2, e); end
      if (i % 2 == 1) begin
        k = (i + 1) / 2;
        exp_cnt = (k > 3) ? 2'd3 : 2'(k);
        n_tests++; if (match_count2 !== exp_cnt) begin n_fail++; $display("FAIL sat_count%0d: got %0d want %0d", k, match_count2, exp_cnt); end
      end
    end
    data_valid = 1'b0;
    n_tests++; if (match_count !== 8'd5) begin n_fail++; $display("FAIL sat_wide_count: got %0d want 5", match_count); end
    load_cfg(8'b11, 4'd2, 1'b0);
    n_tests++; if (match_count2 !== 2'd0) begin n_fail++; $display("FAIL sat_clear: got %0d want 0", match_count2); end
  endtask

  initial begin
    reset = 1'b1; data_in = 1'b0; data_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    test_reset();
    test_basic();
    test_overlap();
    test_gaps();
    test_cfg_err();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
